// File: rtl/pio_multi_out_pkg.sv
// Shared register map, CTRL bit positions and byte-lane merge helper for pio_multi_out.
package pio_multi_out_pkg;

   localparam int MAX_DATA_W = 32;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   localparam logic [1:0] REG_DATA = 2'd0;
   localparam logic [1:0] REG_SET  = 2'd1;
   localparam logic [1:0] REG_CLR  = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   localparam int CTRL_BLINK_BIT = 0;
   localparam int CTRL_BLANK_BIT = 1;

   // Lanes with be=1 take new_word, the rest keep old_word.
   function automatic logic [MAX_DATA_W-1:0] byte_merge(
      input logic [MAX_DATA_W-1:0] old_word,
      input logic [MAX_DATA_W-1:0] new_word,
      input logic [MAX_BE_W-1:0]   be
   );
      logic [MAX_DATA_W-1:0] merged;
      merged = old_word;
      for (int b = 0; b < MAX_BE_W; b++) begin
         if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/pio_multi_out_prescaler.sv
// Shared blink timebase: counts 0..BLINK_DIV-1 and toggles phase on each wrap.
module pio_blink_prescaler #(
   parameter int BLINK_DIV = 25000000
) (
   input  logic clk,
   input  logic reset_n,
   output logic phase
);

   localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_DIV - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= '0;
         phase <= 1'b0;
      end else if (count == LAST) begin
         count <= '0;
         phase <= ~phase;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pio_multi_out.sv
// Multi-channel Avalon-MM output PIO with DATA/SET/CLR/CTRL per channel and blanking.
// Hardware blink is built only when PIO_MULTI_OUT_BLINK_EN is defined.
module pio_multi_out
   import pio_multi_out_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    NUM_CHANNELS = 4,
   parameter int                    ADDR_W       = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL    = '0,
   parameter logic [DATA_WIDTH-1:0] BLANK_VAL    = '1,
   parameter int                    BLINK_DIV    = 25000000
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [ADDR_W-1:0]                address,
   input  logic                             chipselect,
   input  logic                             write_n,
   input  logic                             read_n,
   input  logic [DATA_WIDTH/8-1:0]          byteenable,
   input  logic [DATA_WIDTH-1:0]            writedata,
   output logic [DATA_WIDTH-1:0]            readdata,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_port
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam int CH_W = ADDR_W - 2;

   logic                    wr_en;
   logic                    rd_en;
   logic [CH_W-1:0]         ch_idx;
   logic [1:0]              reg_sel;
   logic [MAX_DATA_W-1:0]   wdata_ext;
   logic [MAX_BE_W-1:0]     be_ext;
   logic [DATA_WIDTH-1:0]   rd_mux;

   logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_flat;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0] ctrl_flat;

   assign wr_en   = chipselect && !write_n;
   assign rd_en   = chipselect && !read_n;
   assign ch_idx  = address[ADDR_W-1:2];
   assign reg_sel = address[1:0];

   always_comb begin
      wdata_ext = '0;
      wdata_ext[DATA_WIDTH-1:0] = writedata;
      be_ext = '0;
      be_ext[BE_W-1:0] = byteenable;
   end

`ifdef PIO_MULTI_OUT_BLINK_EN
   logic phase;

   pio_blink_prescaler #(
      .BLINK_DIV (BLINK_DIV)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .phase   (phase)
   );
`endif

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      logic                  hit;
      logic [DATA_WIDTH-1:0] data_q;
      logic [DATA_WIDTH-1:0] data_nxt;
      logic [DATA_WIDTH-1:0] out_q;
      logic [DATA_WIDTH-1:0] ctrl_word;
      logic [MAX_DATA_W-1:0] data_ext;
      logic [MAX_DATA_W-1:0] merge_src;
      logic [MAX_DATA_W-1:0] merged;
      logic                  blank_q;
      logic                  blanked;

      assign hit = wr_en && (ch_idx == CH_W'(c));

      // SET/CLR compute the full new word first, then byte_merge keeps disabled lanes.
      always_comb begin
         data_ext = '0;
         data_ext[DATA_WIDTH-1:0] = data_q;
         merge_src = wdata_ext;
         case (reg_sel)
            REG_SET: merge_src = data_ext | wdata_ext;
            REG_CLR: merge_src = data_ext & ~wdata_ext;
            default: merge_src = wdata_ext;
         endcase
         merged   = byte_merge(data_ext, merge_src, be_ext);
         data_nxt = merged[DATA_WIDTH-1:0];
      end

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            data_q  <= RESET_VAL;
            blank_q <= 1'b0;
         end else if (hit) begin
            if (reg_sel == REG_CTRL) begin
               if (byteenable[0]) blank_q <= writedata[CTRL_BLANK_BIT];
            end else begin
               data_q <= data_nxt;
            end
         end
      end

`ifdef PIO_MULTI_OUT_BLINK_EN
      logic blink_q;

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            blink_q <= 1'b0;
         end else if (hit && (reg_sel == REG_CTRL) && byteenable[0]) begin
            blink_q <= writedata[CTRL_BLINK_BIT];
         end
      end

      assign blanked = blank_q || (blink_q && phase);

      always_comb begin
         ctrl_word = '0;
         ctrl_word[CTRL_BLANK_BIT] = blank_q;
         ctrl_word[CTRL_BLINK_BIT] = blink_q;
      end
`else
      assign blanked = blank_q;

      always_comb begin
         ctrl_word = '0;
         ctrl_word[CTRL_BLANK_BIT] = blank_q;
      end
`endif

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            out_q <= RESET_VAL;
         end else begin
            out_q <= blanked ? BLANK_VAL : data_q;
         end
      end

      assign data_flat[c*DATA_WIDTH +: DATA_WIDTH] = data_q;
      assign ctrl_flat[c*DATA_WIDTH +: DATA_WIDTH] = ctrl_word;
      assign out_port[c*DATA_WIDTH +: DATA_WIDTH]  = out_q;
   end

   // Unmatched channel indices leave rd_mux at zero.
   always_comb begin
      rd_mux = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (ch_idx == CH_W'(c)) begin
            rd_mux = (reg_sel == REG_CTRL) ? ctrl_flat[c*DATA_WIDTH +: DATA_WIDTH]
                                           : data_flat[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         readdata <= '0;
      end else if (rd_en) begin
         readdata <= rd_mux;
      end
   end

endmodule

// File: doc/pio_multi_out.md
Name: pio_multi_out

Overview:
- Parametrised successor to the single 32-bit Avalon-MM output PIO that drives the HEX displays.
- Provides NUM_CHANNELS independent output words on one Avalon-MM slave, each with write/set/clear/control access and byte enables.
- Adds optional hardware blink/blank per channel, so software no longer bit-bangs display flashing.
- Sits between the Nios II/HPS interconnect and the board displays/LEDs; registered read latency of 1.

Parameters:
- DATA_WIDTH, 32, width of each channel word; multiple of 8, range 8..32.
- NUM_CHANNELS, 4, number of output channels, 1..16.
- ADDR_W, 4, slave word-address width; must be >= clog2(NUM_CHANNELS)+2.
- RESET_VAL, 0, DATA register value after reset.
- BLANK_VAL, all-ones, value driven on a channel while it is blanked (active-low 7-segment off).
- BLINK_DIV, 25000000, clk cycles per blink half-period; >= 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous reset, active low; sampled on the rising edge of clk.
- address  in  ADDR_W  word address; [ADDR_W-1:2] = channel index, [1:0] = register select.
- chipselect  in  1  slave select.
- write_n  in  1  write strobe, active low; qualified by chipselect.
- read_n  in  1  read strobe, active low; qualified by chipselect.
- byteenable  in  DATA_WIDTH/8  byte lanes for writes.
- writedata  in  DATA_WIDTH  write data.
- readdata  out  DATA_WIDTH  read data, valid the cycle after the read strobe.
- out_port  out  NUM_CHANNELS*DATA_WIDTH  channel c on bits [c*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Register select per channel:
  - 0 DATA: R/W.
  - 1 SET: W, DATA |= wdata. Reads return DATA.
  - 2 CLR: W, DATA &= ~wdata. Reads return DATA.
  - 3 CTRL: R/W; bit0 BLINK_EN, bit1 BLANK; other bits read 0.
- Write is accepted when chipselect=1 and write_n=0. Only lanes with byteenable=1 are modified, for all write registers including SET and CLR.
- A write takes effect on DATA/CTRL at the clock edge; out_port reflects it the following cycle (registered output, 1-cycle latency).
- Read:
  - readdata registers the selected value when chipselect=1 and read_n=0; it holds its value otherwise.
  - Read latency is fixed at 1, with no waitrequest.
- Channel index >= NUM_CHANNELS: writes ignored, reads return 0.
- Prescaler:
  - Free-running counter 0..BLINK_DIV-1. On reaching BLINK_DIV-1 it wraps to 0 and toggles `phase`.
  - Counter and phase are shared by all channels, so channels blink in unison.
- Output per channel:
  - BLANK_VAL if BLANK=1, or if BLINK_EN=1 and phase=1.
  - DATA otherwise.
  - BLANK has priority over BLINK_EN.
- Clearing BLINK_EN mid-blink restores DATA on the next cycle. The prescaler is not reset by register writes.
- A write and a phase toggle in the same cycle are independent; both take effect.
- Read and write to the same register in the same cycle: readdata returns the pre-write value.
- Reset (reset_n=0 at an edge), including mid-blink or mid-access:
  - DATA=RESET_VAL, CTRL=0, counter=0, phase=0.
  - readdata=0.
  - out_port = all channels RESET_VAL from the next cycle onward.

Optional Feature:
- PIO_MULTI_OUT_BLINK_EN
- Defined: prescaler, phase and CTRL.BLINK_EN are implemented as above.
- Undefined:
  - No prescaler logic.
  - CTRL bit0 is not stored and reads 0.
  - Output = BLANK ? BLANK_VAL : DATA.
  - BLINK_DIV is unused.

Decomposition:
- Package pio_multi_out_pkg holds:
  - register-select localparams REG_DATA=0, REG_SET=1, REG_CLR=2, REG_CTRL=3;
  - CTRL bit indices CTRL_BLINK_BIT=0, CTRL_BLANK_BIT=1;
  - function byte_merge(old, new, be) returning the byte-lane merged word.
- One sub-module, pio_blink_prescaler (counter plus phase toggle), instantiated only under PIO_MULTI_OUT_BLINK_EN.
- Channel registers are a generate loop in the top.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with writes asserted -> out_port=0 on all channels, readdata=0, writes ignored.
- DATA with byte enables: write ch2 DATA=0xA5A5A5A5 with be=4'b0101 from 0 -> ch2 out=0x00A500A5 one cycle later; ch0/1/3 unchanged; read ch2 DATA returns 0x00A500A5 one cycle after the strobe.
- SET/CLR: ch1 DATA=0x000000F0, then SET 0x0000000F -> 0xFF, then CLR 0x00000081 -> 0x7E; out_port[63:32]=0x7E.
- Blank priority: ch0 DATA=0x12, CTRL=3 -> ch0 out=BLANK_VAL; CTRL=1 -> out alternates 0x12/BLANK_VAL every BLINK_DIV cycles (bench BLINK_DIV=4), starting with 0x12.
- Out of range: NUM_CHANNELS=3, write channel 3 DATA=0xDEAD -> no output change; read returns 0.
- Reset mid-blink: phase=1, ch0 blinking, pulse reset_n for 1 cycle -> phase=0, counter=0, ch0 out=RESET_VAL, CTRL reads 0.
